// File: rtl/idli_mem_sched_if.sv
// idli_mem_sched_if: fetch/LSU request ports and nibble-serial memory pins of the scheduler
interface idli_mem_sched_if;
  logic        i_ifu_req;
  logic [15:0] i_ifu_addr;
  logic        i_ifu_flush;
  logic        o_ifu_gnt;
  logic [3:0]  o_ifu_nib;
  logic        o_ifu_nib_vld;
  logic        i_lsu_req;
  logic        i_lsu_we;
  logic [15:0] i_lsu_addr;
  logic [15:0] i_lsu_wdata;
  logic        o_lsu_gnt;
  logic        o_lsu_done;
  logic [15:0] o_lsu_rdata;
  logic        o_mem_cs_n;
  logic [3:0]  o_mem_sio;
  logic        o_mem_sio_oe;
  logic [3:0]  i_mem_sio;
  modport master (
    input  i_ifu_req, i_ifu_addr, i_ifu_flush, i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_mem_sio,
    output o_ifu_gnt, o_ifu_nib, o_ifu_nib_vld, o_lsu_gnt, o_lsu_done, o_lsu_rdata,
           o_mem_cs_n, o_mem_sio, o_mem_sio_oe
  );
  modport slave (
    output i_ifu_req, i_ifu_addr, i_ifu_flush, i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_mem_sio,
    input  o_ifu_gnt, o_ifu_nib, o_ifu_nib_vld, o_lsu_gnt, o_lsu_done, o_lsu_rdata,
           o_mem_cs_n, o_mem_sio, o_mem_sio_oe
  );
endinterface

// File: rtl/idli_mem_sched_m.sv
// idli_mem_sched_m: round-robin scheduler of fetch and LSU onto a nibble-serial memory port
module idli_mem_sched_m #(
  parameter int         DUMMY_CYCLES = 2,
  parameter logic [3:0] CMD_RD       = 4'h3,
  parameter logic [3:0] CMD_WR       = 4'h2
) (
  input logic              i_dcd_gck,
  input logic              i_dcd_rst_n,
  idli_mem_sched_if.master io_bus
);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END} state_t;
  state_t      r_st, w_nxt;
  logic [7:0]  r_cnt;
  logic        r_ifu, r_we, r_pri_lsu, r_fl, r_nib_vld;
  logic [15:0] r_sh, r_wd, r_rdata;
  logic [3:0]  r_nib;
  logic        w_gnt_i, w_gnt_l, w_last, w_wdat;
  assign w_gnt_i = r_st == S_IDLE && i_dcd_rst_n && io_bus.i_ifu_req && (!io_bus.i_lsu_req || !r_pri_lsu);
  assign w_gnt_l = r_st == S_IDLE && i_dcd_rst_n && io_bus.i_lsu_req && !w_gnt_i;
  assign w_last  = r_cnt == (r_st == S_DUMMY ? 8'(DUMMY_CYCLES - 1) : 8'd3);
  assign w_wdat  = r_st == S_DATA && r_we;
  assign io_bus.o_ifu_gnt     = w_gnt_i;
  assign io_bus.o_lsu_gnt     = w_gnt_l;
  assign io_bus.o_ifu_nib     = r_nib;
  assign io_bus.o_ifu_nib_vld = r_nib_vld;
  assign io_bus.o_lsu_done    = r_st == S_END && !r_ifu;
  assign io_bus.o_lsu_rdata   = r_rdata;
  assign io_bus.o_mem_cs_n    = r_st == S_IDLE || r_st == S_END;
  assign io_bus.o_mem_sio_oe  = r_st == S_CMD || r_st == S_ADDR || w_wdat;
  assign io_bus.o_mem_sio     = r_st == S_CMD ? (r_we ? CMD_WR : CMD_RD) :
                                r_st == S_ADDR ? r_sh[15:12] : w_wdat ? r_sh[3:0] : 4'h0;
  // next phase: dummy phase exists only for reads
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      S_IDLE:  w_nxt = (w_gnt_i || w_gnt_l) ? S_CMD : S_IDLE;
      S_CMD:   w_nxt = S_ADDR;
      S_ADDR:  w_nxt = w_last ? (r_we ? S_DATA : S_DUMMY) : S_ADDR;
      S_DUMMY: w_nxt = w_last ? S_DATA : S_DUMMY;
      S_DATA:  w_nxt = w_last ? S_END : S_DATA;
      default: w_nxt = S_IDLE;
    endcase
  end
  // phase register and per-phase cycle counter, cleared on every phase change
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      r_st  <= S_IDLE;
      r_cnt <= '0;
    end else begin
      r_st  <= w_nxt;
      r_cnt <= (w_nxt != r_st) ? 8'd0 : r_cnt + 8'd1;
    end
  end
  // one shift register carries the address out, write data out, or read data in
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      r_ifu     <= 1'b0;
      r_we      <= 1'b0;
      r_pri_lsu <= 1'b0;
      r_fl      <= 1'b0;
      r_sh      <= '0;
      r_wd      <= '0;
      r_rdata   <= '0;
      r_nib     <= '0;
      r_nib_vld <= 1'b0;
    end else begin
      r_nib_vld <= r_st == S_DATA && r_ifu && !r_fl && !io_bus.i_ifu_flush;
      r_fl      <= w_gnt_i ? io_bus.i_ifu_flush : (r_fl || io_bus.i_ifu_flush);
      if (r_st == S_DATA && r_ifu) r_nib <= io_bus.i_mem_sio;
      if (w_gnt_i || w_gnt_l) begin
        r_ifu     <= w_gnt_i;
        r_we      <= w_gnt_l && io_bus.i_lsu_we;
        r_pri_lsu <= w_gnt_i;
        r_sh      <= w_gnt_i ? io_bus.i_ifu_addr : io_bus.i_lsu_addr;
        r_wd      <= io_bus.i_lsu_wdata;
      end else if (r_st == S_ADDR) r_sh <= (w_last && r_we) ? r_wd : {r_sh[11:0], 4'h0};
      else if (r_st == S_DATA) r_sh <= {r_we ? 4'h0 : io_bus.i_mem_sio, r_sh[15:4]};
      if (r_st == S_DATA && w_last && !r_ifu && !r_we) r_rdata <= {io_bus.i_mem_sio, r_sh[15:4]};
    end
  end
endmodule

// File: tb/tb_idli_mem_sched_m.sv
// tb_idli_mem_sched_m: table vectors, corner sequences and a randomized timeline model
module tb_idli_mem_sched_m;
  localparam int DUMMY = 2;
  localparam int T = 1500;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  idli_mem_sched_if u_if();
  idli_mem_sched_m #(.DUMMY_CYCLES(DUMMY), .CMD_RD(4'h3), .CMD_WR(4'h2)) u_dut (
    .i_dcd_gck(clk), .i_dcd_rst_n(rst_n), .io_bus(u_if.master));
  always #5 clk = ~clk;

  typedef struct {
    logic lsu, we;
    logic [15:0] addr, wdata, mem;
    logic [35:0] sio;
    int n_oe, n_vld;
    logic [15:0] nibs;
    int n_done;
    logic [15:0] rdata;
    int len;
  } vec_t;
  typedef struct packed {
    logic cs_n, oe;
    logic [3:0] sio;
    logic gi, gl, done, vld;
    logic [3:0] nib;
  } ex_t;
  ex_t ex [T+40];
  logic [3:0] mem_n [T+40];
  logic fl [T+40];
  logic rd_set [T+40];
  logic [15:0] rd_val [T+40];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    u_if.i_ifu_req = 1'b0; u_if.i_ifu_addr = '0; u_if.i_ifu_flush = 1'b0;
    u_if.i_lsu_req = 1'b0; u_if.i_lsu_we = 1'b0; u_if.i_lsu_addr = '0; u_if.i_lsu_wdata = '0;
    u_if.i_mem_sio = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {u_if.o_mem_cs_n, u_if.o_mem_sio_oe, u_if.o_mem_sio, u_if.o_ifu_gnt,
        u_if.o_lsu_gnt, u_if.o_ifu_nib_vld, u_if.o_lsu_done, u_if.o_lsu_rdata}, {1'b1, 25'h0});
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [35:0] s = '0;
    logic [15:0] nibs = '0;
    int n_oe = 0, n_vld = 0, n_done = 0, len = 0;
    int ds = 6 + ((v.lsu && v.we) ? 0 : DUMMY);
    logic g = 1'b0;
    @(posedge clk); #1;
    if (v.lsu) begin
      u_if.i_lsu_req = 1'b1; u_if.i_lsu_we = v.we; u_if.i_lsu_addr = v.addr; u_if.i_lsu_wdata = v.wdata;
    end else begin
      u_if.i_ifu_req = 1'b1; u_if.i_ifu_addr = v.addr;
    end
    for (int c = 0; c < 20; c++) begin
      u_if.i_mem_sio = (c >= ds && c < ds + 4) ? v.mem[4*(c-ds) +: 4] : 4'($urandom);
      @(negedge clk);
      if (c == 0) g = v.lsu ? (u_if.o_lsu_gnt && !u_if.o_ifu_gnt) : (u_if.o_ifu_gnt && !u_if.o_lsu_gnt);
      if (!u_if.o_mem_cs_n && u_if.o_mem_sio_oe) begin s = {s[31:0], u_if.o_mem_sio}; n_oe++; end
      if (u_if.o_ifu_nib_vld) begin nibs = {u_if.o_ifu_nib, nibs[15:4]}; n_vld++; end
      if (u_if.o_lsu_done) n_done++;
      if (c > 0 && u_if.o_mem_cs_n && len == 0) len = c + 1;
      @(posedge clk); #1;
      u_if.i_ifu_req = 1'b0; u_if.i_lsu_req = 1'b0;
    end
    chk($sformatf("v%0d_gnt", id), g, 1);
    chk($sformatf("v%0d_sio", id), s, v.sio);
    chk($sformatf("v%0d_n_oe", id), n_oe, v.n_oe);
    chk($sformatf("v%0d_n_vld", id), n_vld, v.n_vld);
    chk($sformatf("v%0d_nibs", id), nibs, v.nibs);
    chk($sformatf("v%0d_n_done", id), n_done, v.n_done);
    chk($sformatf("v%0d_rdata", id), u_if.o_lsu_rdata, v.rdata);
    chk($sformatf("v%0d_len", id), len, v.len);
  endtask

  function automatic int sched(int t, logic lsu, logic we, logic [15:0] a, logic [15:0] wd);
    int ds = t + 6 + (we ? 0 : DUMMY);
    logic dead = 1'b0;
    if (lsu) ex[t].gl = 1'b1; else ex[t].gi = 1'b1;
    for (int k = t + 1; k < ds + 4; k++) ex[k].cs_n = 1'b0;
    ex[t+1].oe = 1'b1;
    ex[t+1].sio = we ? 4'h2 : 4'h3;
    for (int k = 0; k < 4; k++) begin
      ex[t+2+k].oe = 1'b1;
      ex[t+2+k].sio = a[15-4*k -: 4];
      if (we) begin ex[ds+k].oe = 1'b1; ex[ds+k].sio = wd[4*k +: 4]; end
    end
    if (lsu) ex[ds+4].done = 1'b1;
    if (lsu && !we) begin
      rd_set[ds+4] = 1'b1;
      rd_val[ds+4] = {mem_n[ds+3], mem_n[ds+2], mem_n[ds+1], mem_n[ds]};
    end
    if (!lsu) for (int k = t; k < ds + 4; k++) begin
      dead = dead | fl[k];
      if (k >= ds && !dead) begin ex[k+1].vld = 1'b1; ex[k+1].nib = mem_n[k]; end
    end
    return ds + 5;
  endfunction

  initial begin
    vec_t vt[5];
    int gt[4] = '{-1, -1, -1, -1};
    int gt_exp[4] = '{0, 13, 24, 37};
    logic gw[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int n = 0, nv = 0, nl = 0, nd = 0, lg = -1, free_at = 0;
    logic [15:0] rdv = '0, ia = '0, la = '0, lwd = '0, m_rd = '0;
    logic pri_lsu = 1'b0, pi = 1'b0, pl = 1'b0, lwe = 1'b0, sel = 1'b0, gnt = 1'b0;
    vt[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hDCBA, 36'h31234, 5, 4, 16'hDCBA, 0, 16'h0000, 13};
    vt[1] = '{1'b1, 1'b1, 16'h00F0, 16'hBEEF, 16'h0000, 36'h200F0FEEB, 9, 0, 16'h0000, 1, 16'h0000, 11};
    vt[2] = '{1'b1, 1'b0, 16'h4321, 16'h0000, 16'h8765, 36'h34321, 5, 0, 16'h0000, 1, 16'h8765, 13};
    vt[3] = '{1'b1, 1'b1, 16'hABCD, 16'h1357, 16'h0000, 36'h2ABCD7531, 9, 0, 16'h0000, 1, 16'h8765, 11};
    vt[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 36'h3FFFF, 5, 4, 16'h0F0F, 0, 16'h8765, 13};
    for (int i = 0; i < T + 40; i++) begin
      ex[i] = '0;
      ex[i].cs_n = 1'b1;
      mem_n[i] = 4'($urandom);
      fl[i] = $urandom_range(0, 29) == 0;
      rd_set[i] = 1'b0;
      rd_val[i] = '0;
    end
    do_reset();
    for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

    do_reset();
    @(posedge clk); #1;
    u_if.i_ifu_req = 1'b1; u_if.i_lsu_req = 1'b1; u_if.i_lsu_we = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if ((u_if.o_ifu_gnt || u_if.o_lsu_gnt) && n < 4) begin gt[n] = c; gw[n] = u_if.o_lsu_gnt; n++; end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("arb_time%0d", k), gt[k], gt_exp[k]);
      chk($sformatf("arb_who%0d", k), gw[k], k % 2);
    end
    idle_inputs();
    repeat (20) @(posedge clk);
    #1;

    u_if.i_ifu_req = 1'b1; u_if.i_ifu_addr = 16'h0040; u_if.i_mem_sio = 4'h9;
    for (int c = 0; c < 32; c++) begin
      if (c == 1) begin u_if.i_ifu_req = 1'b0; u_if.i_lsu_req = 1'b1; u_if.i_lsu_we = 1'b0; end
      if (lg >= 0) u_if.i_lsu_req = 1'b0;
      u_if.i_ifu_flush = c >= 10;
      @(negedge clk);
      if (u_if.o_ifu_nib_vld) nv++;
      if (!u_if.o_mem_cs_n && c < 13) nl++;
      if (u_if.o_lsu_gnt && lg < 0) lg = c;
      if (u_if.o_lsu_done) begin nd++; rdv = u_if.o_lsu_rdata; end
      @(posedge clk); #1;
    end
    chk("flush_n_vld", nv, 2);
    chk("flush_cs_low", nl, 11);
    chk("flush_next_gnt", lg, 13);
    chk("flush_lsu_done", nd, 1);
    chk("flush_lsu_rdata", rdv, 16'h9999);
    idle_inputs();

    u_if.i_lsu_req = 1'b1; u_if.i_lsu_we = 1'b0; u_if.i_lsu_addr = 16'h5555;
    @(negedge clk);
    chk("rst_lsu_gnt", u_if.o_lsu_gnt, 1);
    @(posedge clk); #1;
    u_if.i_lsu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pre_cs", u_if.o_mem_cs_n, 0);
    u_if.i_ifu_req = 1'b1; u_if.i_lsu_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {u_if.o_mem_cs_n, u_if.o_mem_sio_oe}, 2'b10);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (u_if.o_lsu_done || u_if.o_ifu_nib_vld) nd++;
    end
    chk("rst_no_done", nd, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_gnt", {u_if.o_ifu_gnt, u_if.o_lsu_gnt}, 2'b10);
    @(posedge clk); #1;
    idle_inputs();
    repeat (20) @(posedge clk);

    do_reset();
    for (int t = 0; t < T; t++) begin
      @(posedge clk); #1;
      if (!pi && $urandom_range(0, 3) == 0) begin pi = 1'b1; ia = 16'($urandom); end
      if (!pl && $urandom_range(0, 4) == 0) begin
        pl = 1'b1; lwe = 1'($urandom); la = 16'($urandom); lwd = 16'($urandom);
      end
      gnt = 1'b0;
      if (t >= free_at && (pi || pl)) begin
        sel = pl && (!pi || pri_lsu);
        free_at = sched(t, sel, sel && lwe, sel ? la : ia, lwd);
        pri_lsu = !sel;
        gnt = 1'b1;
      end
      u_if.i_ifu_req = pi; u_if.i_ifu_addr = ia; u_if.i_ifu_flush = fl[t];
      u_if.i_lsu_req = pl; u_if.i_lsu_we = lwe; u_if.i_lsu_addr = la; u_if.i_lsu_wdata = lwd;
      u_if.i_mem_sio = mem_n[t];
      @(negedge clk);
      if (rd_set[t]) m_rd = rd_val[t];
      chk($sformatf("rand_t%0d", t),
          {u_if.o_mem_cs_n, u_if.o_mem_sio_oe, u_if.o_mem_sio_oe ? u_if.o_mem_sio : 4'h0,
           u_if.o_ifu_gnt, u_if.o_lsu_gnt, u_if.o_lsu_done, u_if.o_ifu_nib_vld,
           u_if.o_ifu_nib_vld ? u_if.o_ifu_nib : 4'h0, u_if.o_lsu_rdata},
          {ex[t], m_rd});
      if (gnt) begin
        if (sel) pl = 1'b0; else pi = 1'b0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
